// File: rtl/qs_bank_sched_if.sv
// Job handshake bundle between the bank scheduler and its enqueue/sort/dequeue engines.
// The master side is the scheduler; the slave side is the engine cluster.
interface qs_bank_sched_if #(
    parameter int BANKS_N = 4,
    parameter int N_W     = 8
);
    localparam int BID_W = $clog2(BANKS_N);

    logic             enq_start_vld_r;
    logic [BID_W-1:0] enq_start_bank_r;
    logic             enq_start_ack;
    logic             enq_done_vld;
    logic [N_W-1:0]   enq_done_n;
    logic             enq_done_err;

    logic             sort_start_vld_r;
    logic [BID_W-1:0] sort_start_bank_r;
    logic [N_W-1:0]   sort_start_n_r;
    logic             sort_start_ack;
    logic             sort_done_vld;

    logic             deq_start_vld_r;
    logic [BID_W-1:0] deq_start_bank_r;
    logic [N_W-1:0]   deq_start_n_r;
    logic             deq_start_err_r;
    logic             deq_start_ack;
    logic             deq_done_vld;

    logic             busy_r;
    logic             proto_err_r;

    modport master (
        output enq_start_vld_r, enq_start_bank_r,
        output sort_start_vld_r, sort_start_bank_r, sort_start_n_r,
        output deq_start_vld_r, deq_start_bank_r, deq_start_n_r, deq_start_err_r,
        output busy_r, proto_err_r,
        input  enq_start_ack, enq_done_vld, enq_done_n, enq_done_err,
        input  sort_start_ack, sort_done_vld,
        input  deq_start_ack, deq_done_vld
    );

    modport slave (
        input  enq_start_vld_r, enq_start_bank_r,
        input  sort_start_vld_r, sort_start_bank_r, sort_start_n_r,
        input  deq_start_vld_r, deq_start_bank_r, deq_start_n_r, deq_start_err_r,
        input  busy_r, proto_err_r,
        output enq_start_ack, enq_done_vld, enq_done_n, enq_done_err,
        output sort_start_ack, sort_done_vld,
        output deq_start_ack, deq_done_vld
    );
endinterface

// File: rtl/qs_bank_sched.sv
// Round-robin bank scheduler: three agents (enq, sort, deq) walk the banks in order,
// each offering a bank once it reaches that agent's source state.
//   bank state | meaning                     agent phase | meaning
//   READY      | free, waiting for enq       IDLE        | watching bank at pointer
//   LOADING    | enq engine filling it       OFFER       | start_vld_r high, awaiting ack
//   LOADED     | filled, waiting for sort    ACTIVE      | engine owns the bank until done
//   SORTING    | sort engine working
//   SORTED     | sorted, waiting for deq
//   UNLOADING  | deq engine draining it
module qs_bank_sched #(
    parameter int BANKS_N = 4,
    parameter int N_W     = 8
) (
    input logic             clk,
    input logic             rst,
    qs_bank_sched_if.master bus
);
    localparam int BID_W   = $clog2(BANKS_N);
    localparam int AG_N    = 3;
    localparam int AG_ENQ  = 0;
    localparam int AG_SORT = 1;
    localparam int AG_DEQ  = 2;

    typedef enum logic [2:0] {
        ST_READY, ST_LOADING, ST_LOADED, ST_SORTING, ST_SORTED, ST_UNLOADING
    } bank_st_e;

    typedef enum logic [1:0] {PH_IDLE, PH_OFFER, PH_ACTIVE} phase_e;

    bank_st_e         st_q      [BANKS_N];
    bank_st_e         st_d      [BANKS_N];
    logic [N_W-1:0]   n_q       [BANKS_N];
    logic [N_W-1:0]   n_d       [BANKS_N];
    logic             err_q     [BANKS_N];
    logic             err_d     [BANKS_N];
    phase_e           ph_q      [AG_N];
    phase_e           ph_d      [AG_N];
    logic [BID_W-1:0] ptr_q     [AG_N];
    logic [BID_W-1:0] ptr_d     [AG_N];
    logic [N_W-1:0]   pay_n_q   [AG_N];
    logic [N_W-1:0]   pay_n_d   [AG_N];
    logic             pay_err_q [AG_N];
    logic             pay_err_d [AG_N];
    logic             proto_q, proto_d;
    logic             busy_q, busy_d;
    logic [AG_N-1:0]  ack;
    logic [AG_N-1:0]  done;

    assign ack  = {bus.deq_start_ack, bus.sort_start_ack, bus.enq_start_ack};
    assign done = {bus.deq_done_vld, bus.sort_done_vld, bus.enq_done_vld};

    function automatic bank_st_e src_st(int a);
        case (a)
            AG_ENQ:  return ST_READY;
            AG_SORT: return ST_LOADED;
            default: return ST_SORTED;
        endcase
    endfunction

    function automatic bank_st_e busy_st(int a);
        case (a)
            AG_ENQ:  return ST_LOADING;
            AG_SORT: return ST_SORTING;
            default: return ST_UNLOADING;
        endcase
    endfunction

    function automatic bank_st_e done_st(int a);
        case (a)
            AG_ENQ:  return ST_LOADED;
            AG_SORT: return ST_SORTED;
            default: return ST_READY;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS_N; b++) begin
                st_q[b]  <= ST_READY;
                n_q[b]   <= '0;
                err_q[b] <= 1'b0;
            end
            for (int a = 0; a < AG_N; a++) begin
                ph_q[a]      <= PH_IDLE;
                ptr_q[a]     <= '0;
                pay_n_q[a]   <= '0;
                pay_err_q[a] <= 1'b0;
            end
            proto_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            st_q      <= st_d;
            n_q       <= n_d;
            err_q     <= err_d;
            ph_q      <= ph_d;
            ptr_q     <= ptr_d;
            pay_n_q   <= pay_n_d;
            pay_err_q <= pay_err_d;
            proto_q   <= proto_d;
            busy_q    <= busy_d;
        end
    end

    // Agents never touch the same bank in one cycle, so their bank writes cannot collide.
    always_comb begin
        st_d      = st_q;
        n_d       = n_q;
        err_d     = err_q;
        ph_d      = ph_q;
        ptr_d     = ptr_q;
        pay_n_d   = pay_n_q;
        pay_err_d = pay_err_q;
        proto_d   = proto_q;
        for (int a = 0; a < AG_N; a++) begin
            if (ack[a] && ph_q[a] != PH_OFFER)
                proto_d = 1'b1;
            if (done[a] && ph_q[a] != PH_ACTIVE)
                proto_d = 1'b1;
            case (ph_q[a])
                PH_IDLE: begin
                    if (st_q[ptr_q[a]] == src_st(a)) begin
                        ph_d[a]      = PH_OFFER;
                        pay_n_d[a]   = n_q[ptr_q[a]];
                        pay_err_d[a] = err_q[ptr_q[a]];
                    end
                end
                PH_OFFER: begin
                    if (ack[a]) begin
                        ph_d[a]          = PH_ACTIVE;
                        st_d[ptr_q[a]]   = busy_st(a);
                    end
                end
                PH_ACTIVE: begin
                    if (done[a]) begin
                        ph_d[a]        = PH_IDLE;
                        st_d[ptr_q[a]] = done_st(a);
                        ptr_d[a]       = ptr_q[a] + BID_W'(1);
                        if (a == AG_ENQ) begin
                            n_d[ptr_q[a]]   = bus.enq_done_n;
                            err_d[ptr_q[a]] = bus.enq_done_err;
                        end
                        if (a == AG_DEQ)
                            err_d[ptr_q[a]] = 1'b0;
                    end
                end
                default: ph_d[a] = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int b = 0; b < BANKS_N; b++)
            if (st_d[b] != ST_READY)
                busy_d = 1'b1;
        bus.enq_start_vld_r   = (ph_q[AG_ENQ] == PH_OFFER);
        bus.enq_start_bank_r  = ptr_q[AG_ENQ];
        bus.sort_start_vld_r  = (ph_q[AG_SORT] == PH_OFFER);
        bus.sort_start_bank_r = ptr_q[AG_SORT];
        bus.sort_start_n_r    = pay_n_q[AG_SORT];
        bus.deq_start_vld_r   = (ph_q[AG_DEQ] == PH_OFFER);
        bus.deq_start_bank_r  = ptr_q[AG_DEQ];
        bus.deq_start_n_r     = pay_n_q[AG_DEQ];
        bus.deq_start_err_r   = pay_err_q[AG_DEQ];
        bus.busy_r            = busy_q;
        bus.proto_err_r       = proto_q;
    end
endmodule
